memory_access_stage: RTL and testbench

- MEM stage between the execute stage (ALU) and register write-back.
- Takes the EX result and control bits and runs loads/stores over a handshaked data bus with variable wait states.
- Handles byte/half/word lanes and load sign/zero extension, and stalls upstream while a bus access is outstanding.
- Non-memory instructions pass to write-back with one-cycle latency.

---
 rtl/memory_access_stage_if.sv | 23 ++
 rtl/memory_access_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_memory_access_stage.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_stage_if.sv
// Data-bus handshake between the MEM stage (master) and data memory (slave).
interface memory_access_stage_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    logic              bus_request;
    logic              bus_write;
    logic [DATA_W-1:0] bus_address;
    logic [BE_W-1:0]   bus_byte_enable;
    logic [DATA_W-1:0] bus_write_data;
    logic              bus_ready;
    logic [DATA_W-1:0] bus_read_data;

    modport master (
        output bus_request, bus_write, bus_address, bus_byte_enable, bus_write_data,
        input  bus_ready, bus_read_data
    );

    modport slave (
        input  bus_request, bus_write, bus_address, bus_byte_enable, bus_write_data,
        output bus_ready, bus_read_data
    );
endinterface

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: runs loads/stores over a wait-stated data bus with lane
// steering and load extension; non-memory results pass to write-back in one cycle.
module memory_access_stage #(
    parameter  int unsigned TIMEOUT_CYCLES = 16,
    localparam int unsigned DATA_W         = 32,
    localparam int unsigned REG_W          = 5,
    localparam int unsigned BE_W           = 4
) (
    input  logic              system_clock,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_memory_read,
    input  logic              ex_memory_write,
    input  logic [1:0]        ex_access_size,
    input  logic              ex_load_unsigned,
    input  logic              ex_register_write,
    input  logic [REG_W-1:0]  ex_write_address,
    output logic              stall,
    memory_access_stage_if.master bus,
    output logic              wb_valid,
    output logic              wb_register_write,
    output logic [REG_W-1:0]  wb_write_address,
    output logic [DATA_W-1:0] wb_write_data,
    output logic              address_error,
    output logic              bus_error
);

    localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       SIZE_BYTE = 2'b00;
    localparam logic [1:0]       SIZE_HALF = 2'b01;
    localparam logic [1:0]       SIZE_WORD = 2'b10;
    localparam logic [1:0]       SIZE_RSVD = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              request_q, request_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] address_q, address_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        lane_q, lane_d;
    logic              load_unsigned_q, load_unsigned_d;
    logic              reg_write_q, reg_write_d;
    logic [REG_W-1:0]  write_address_q, write_address_d;

    logic              wb_valid_d;
    logic              wb_register_write_d;
    logic [REG_W-1:0]  wb_write_address_d;
    logic [DATA_W-1:0] wb_write_data_d;
    logic              address_error_d;
    logic              bus_error_d;
    logic              stall_c;

    logic              ex_is_mem;
    logic              ex_illegal;
    logic [BE_W-1:0]   ex_be;
    logic [DATA_W-1:0] ex_wdata;
    logic [15:0]       lane_data;
    logic [DATA_W-1:0] load_data;

    // Classify the EX instruction and build lane enables / replicated store data.
    always_comb begin : ex_decode
        ex_is_mem  = ex_memory_read | ex_memory_write;
        ex_illegal = (ex_memory_read & ex_memory_write)
                   | (ex_access_size == SIZE_RSVD)
                   | ((ex_access_size == SIZE_HALF) && ex_alu_result[0])
                   | ((ex_access_size == SIZE_WORD) && (ex_alu_result[1:0] != 2'b00));
        ex_be      = 4'b1111;
        ex_wdata   = ex_store_data;
        case (ex_access_size)
            SIZE_BYTE: begin
                ex_be    = BE_W'(1) << ex_alu_result[1:0];
                ex_wdata = {4{ex_store_data[7:0]}};
            end
            SIZE_HALF: begin
                ex_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                ex_wdata = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    always_comb begin : load_align
        lane_data = 16'(bus.bus_read_data >> {lane_q, 3'b000});
        load_data = bus.bus_read_data;
        case (size_q)
            SIZE_BYTE: load_data = load_unsigned_q ? {24'b0, lane_data[7:0]}
                                                   : {{24{lane_data[7]}}, lane_data[7:0]};
            SIZE_HALF: load_data = load_unsigned_q ? {16'b0, lane_data}
                                                   : {{16{lane_data[15]}}, lane_data};
            default:   ;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin : fsm_next
        state_d             = state_q;
        count_d             = count_q;
        request_d           = request_q;
        write_d             = write_q;
        address_d           = address_q;
        be_d                = be_q;
        wdata_d             = wdata_q;
        size_d              = size_q;
        lane_d              = lane_q;
        load_unsigned_d     = load_unsigned_q;
        reg_write_d         = reg_write_q;
        write_address_d     = write_address_q;
        wb_valid_d          = 1'b0;
        wb_register_write_d = 1'b0;
        wb_write_address_d  = wb_write_address;
        wb_write_data_d     = wb_write_data;
        address_error_d     = 1'b0;
        bus_error_d         = 1'b0;
        stall_c             = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    if (!ex_is_mem) begin
                        wb_valid_d          = 1'b1;
                        wb_register_write_d = ex_register_write;
                        wb_write_address_d  = ex_write_address;
                        wb_write_data_d     = ex_alu_result;
                    end else if (ex_illegal) begin
                        wb_valid_d          = 1'b1;
                        wb_write_address_d  = ex_write_address;
                        address_error_d     = 1'b1;
                    end else begin
                        stall_c         = 1'b1;
                        state_d         = S_BUS;
                        count_d         = '0;
                        request_d       = 1'b1;
                        write_d         = ex_memory_write;
                        address_d       = {ex_alu_result[DATA_W-1:2], 2'b00};
                        be_d            = ex_be;
                        wdata_d         = ex_wdata;
                        size_d          = ex_access_size;
                        lane_d          = ex_alu_result[1:0];
                        load_unsigned_d = ex_load_unsigned;
                        reg_write_d     = ex_register_write;
                        write_address_d = ex_write_address;
                    end
                end
            end
            S_BUS: begin
                // Completion takes priority over a timeout in the same cycle.
                if (bus.bus_ready) begin
                    state_d             = S_IDLE;
                    request_d           = 1'b0;
                    wb_valid_d          = 1'b1;
                    wb_register_write_d = !write_q && reg_write_q;
                    wb_write_address_d  = write_address_q;
                    if (!write_q) begin
                        wb_write_data_d = load_data;
                    end
                end else if (count_q >= LAST_CNT) begin
                    state_d            = S_IDLE;
                    request_d          = 1'b0;
                    wb_valid_d         = 1'b1;
                    wb_write_address_d = write_address_q;
                    bus_error_d        = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage register.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q           <= S_IDLE;
            count_q           <= '0;
            request_q         <= 1'b0;
            write_q           <= 1'b0;
            address_q         <= '0;
            be_q              <= '0;
            wdata_q           <= '0;
            size_q            <= '0;
            lane_q            <= '0;
            load_unsigned_q   <= 1'b0;
            reg_write_q       <= 1'b0;
            write_address_q   <= '0;
            wb_valid          <= 1'b0;
            wb_register_write <= 1'b0;
            wb_write_address  <= '0;
            wb_write_data     <= '0;
            address_error     <= 1'b0;
            bus_error         <= 1'b0;
        end else begin
            state_q           <= state_d;
            count_q           <= count_d;
            request_q         <= request_d;
            write_q           <= write_d;
            address_q         <= address_d;
            be_q              <= be_d;
            wdata_q           <= wdata_d;
            size_q            <= size_d;
            lane_q            <= lane_d;
            load_unsigned_q   <= load_unsigned_d;
            reg_write_q       <= reg_write_d;
            write_address_q   <= write_address_d;
            wb_valid          <= wb_valid_d;
            wb_register_write <= wb_register_write_d;
            wb_write_address  <= wb_write_address_d;
            wb_write_data     <= wb_write_data_d;
            address_error     <= address_error_d;
            bus_error         <= bus_error_d;
        end
    end

    assign stall               = stall_c & ~reset;
    assign bus.bus_request     = request_q;
    assign bus.bus_write       = write_q;
    assign bus.bus_address     = address_q;
    assign bus.bus_byte_enable = be_q;
    assign bus.bus_write_data  = wdata_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed scenarios plus random op streams
// checked against a transaction-level model of the stage.
module tb_memory_access_stage;

    localparam int T = 4;

    logic        system_clock = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_memory_read;
    logic        ex_memory_write;
    logic [1:0]  ex_access_size;
    logic        ex_load_unsigned;
    logic        ex_register_write;
    logic [4:0]  ex_write_address;
    logic        stall;
    logic        wb_valid;
    logic        wb_register_write;
    logic [4:0]  wb_write_address;
    logic [31:0] wb_write_data;
    logic        address_error;
    logic        bus_error;

    memory_access_stage_if bus_if ();

    memory_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .system_clock      (system_clock),
        .reset             (reset),
        .ex_valid          (ex_valid),
        .ex_alu_result     (ex_alu_result),
        .ex_store_data     (ex_store_data),
        .ex_memory_read    (ex_memory_read),
        .ex_memory_write   (ex_memory_write),
        .ex_access_size    (ex_access_size),
        .ex_load_unsigned  (ex_load_unsigned),
        .ex_register_write (ex_register_write),
        .ex_write_address  (ex_write_address),
        .stall             (stall),
        .bus               (bus_if),
        .wb_valid          (wb_valid),
        .wb_register_write (wb_register_write),
        .wb_write_address  (wb_write_address),
        .wb_write_data     (wb_write_data),
        .address_error     (address_error),
        .bus_error         (bus_error)
    );

    always #5 system_clock = ~system_clock;

    int          total = 0;
    int          bad   = 0;
    int          obs_stall_cycles;
    int          obs_req_cycles;
    logic [31:0] obs_bus_address;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic illegal_model(input logic rd, input logic wr,
                                           input logic [1:0] sz, input logic [1:0] lane);
        return (rd && wr) || (sz == 2'd3) || ((int'(lane) % nbytes(sz)) != 0);
    endfunction

    function automatic logic [3:0] be_model(input logic [1:0] sz, input logic [1:0] lane);
        int n = nbytes(sz);
        return 4'(((1 << n) - 1) << lane);
    endfunction

    function automatic logic [31:0] wdata_model(input logic [1:0] sz, input logic [31:0] sd);
        int n = nbytes(sz);
        logic [31:0] piece, acc;
        piece = (n == 4) ? sd : (sd & ((32'h1 << (8 * n)) - 32'h1));
        acc = 32'h0;
        for (int i = 0; i < 4; i += n) acc = acc | (piece << (8 * i));
        return acc;
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] rdata, input logic [1:0] lane,
                                               input logic [1:0] sz, input logic uns);
        int n = nbytes(sz);
        logic [31:0] v, mask;
        v = rdata >> (8 * lane);
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            v = v & mask;
            if (!uns && v[8 * n - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    // Present one instruction, play the bus side, and check every cycle until WB.
    task automatic run_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic rw, input logic [4:0] wa,
                          input logic [31:0] alu, input logic [31:0] sd,
                          input int wait_n, input logic [31:0] rdata);
        logic       mem, bad_op, exp_stall, exp_rw, ready, done, completed;
        logic [1:0] lane;
        int         k;
        lane = alu[1:0];
        ex_valid = v; ex_memory_read = rd; ex_memory_write = wr; ex_access_size = sz;
        ex_load_unsigned = uns; ex_register_write = rw; ex_write_address = wa;
        ex_alu_result = alu; ex_store_data = sd;
        bus_if.bus_ready = 1'b0; bus_if.bus_read_data = $urandom;
        #1;
        mem       = rd | wr;
        bad_op    = mem && illegal_model(rd, wr, sz, lane);
        exp_stall = v && mem && !bad_op;
        total++;
        if (stall !== exp_stall) begin
            bad++; $display("FAIL accept_stall got=%b exp=%b addr=%h", stall, exp_stall, alu);
        end
        obs_stall_cycles = (stall === 1'b1) ? 1 : 0;
        obs_req_cycles   = 0;
        @(posedge system_clock); @(negedge system_clock); #1;

        if (!exp_stall) begin
            exp_rw = v && !mem && rw;
            total++;
            if (wb_valid !== v || wb_register_write !== exp_rw || bus_if.bus_request !== 1'b0) begin
                bad++; $display("FAIL direct_wb got v=%b rw=%b req=%b exp v=%b rw=%b req=0",
                                wb_valid, wb_register_write, bus_if.bus_request, v, exp_rw);
            end
            total++;
            if (address_error !== (v && bad_op) || bus_error !== 1'b0) begin
                bad++; $display("FAIL direct_err got ae=%b be=%b exp ae=%b be=0",
                                address_error, bus_error, v && bad_op);
            end
            if (v && !mem) begin
                total++;
                if (wb_write_data !== alu || wb_write_address !== wa) begin
                    bad++; $display("FAIL alu_pass got data=%h wa=%0d exp data=%h wa=%0d",
                                    wb_write_data, wb_write_address, alu, wa);
                end
            end
            return;
        end

        k = 0; done = 1'b0; completed = 1'b0;
        while (!done) begin
            total++;
            if (bus_if.bus_request !== 1'b1 || bus_if.bus_address !== {alu[31:2], 2'b00} ||
                bus_if.bus_byte_enable !== be_model(sz, lane) || bus_if.bus_write !== wr) begin
                bad++; $display("FAIL bus_hold cyc=%0d got req=%b a=%h be=%b w=%b exp req=1 a=%h be=%b w=%b",
                                k, bus_if.bus_request, bus_if.bus_address, bus_if.bus_byte_enable,
                                bus_if.bus_write, {alu[31:2], 2'b00}, be_model(sz, lane), wr);
            end
            if (wr) begin
                total++;
                if (bus_if.bus_write_data !== wdata_model(sz, sd)) begin
                    bad++; $display("FAIL bus_wdata got=%h exp=%h", bus_if.bus_write_data, wdata_model(sz, sd));
                end
            end
            total++;
            if (wb_valid !== 1'b0) begin
                bad++; $display("FAIL wb_during_bus got=%b exp=0", wb_valid);
            end
            obs_req_cycles++;
            obs_bus_address = bus_if.bus_address;
            obs_be          = bus_if.bus_byte_enable;
            obs_wdata       = bus_if.bus_write_data;
            // Upstream is stalled; garbage on ex_* must be ignored.
            ex_valid = 1'($urandom); ex_memory_read = 1'($urandom); ex_memory_write = 1'($urandom);
            ex_access_size = 2'($urandom); ex_alu_result = $urandom; ex_store_data = $urandom;
            ex_write_address = 5'($urandom); ex_register_write = 1'($urandom);
            ready = (k == wait_n);
            bus_if.bus_ready = ready;
            bus_if.bus_read_data = ready ? rdata : $urandom;
            #1;
            exp_stall = !ready && (k < T - 1);
            total++;
            if (stall !== exp_stall) begin
                bad++; $display("FAIL bus_stall cyc=%0d got=%b exp=%b", k, stall, exp_stall);
            end
            if (stall === 1'b1) obs_stall_cycles++;
            if (ready) completed = 1'b1;
            if (ready || k == T - 1) done = 1'b1;
            @(posedge system_clock); @(negedge system_clock); #1;
            k++;
        end
        bus_if.bus_ready = 1'b0;

        exp_rw = completed && rd && rw;
        total++;
        if (bus_if.bus_request !== 1'b0 || wb_valid !== 1'b1 || wb_register_write !== exp_rw) begin
            bad++; $display("FAIL mem_done got req=%b v=%b rw=%b exp req=0 v=1 rw=%b",
                            bus_if.bus_request, wb_valid, wb_register_write, exp_rw);
        end
        total++;
        if (bus_error !== !completed || address_error !== 1'b0 || wb_write_address !== wa) begin
            bad++; $display("FAIL mem_status got be=%b ae=%b wa=%0d exp be=%b ae=0 wa=%0d",
                            bus_error, address_error, wb_write_address, !completed, wa);
        end
        if (completed && rd) begin
            total++;
            if (wb_write_data !== load_model(rdata, lane, sz, uns)) begin
                bad++; $display("FAIL load_data got=%h exp=%h", wb_write_data, load_model(rdata, lane, sz, uns));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ex_valid = 1'b1; ex_memory_read = 1'b1; ex_memory_write = 1'b0; ex_access_size = 2'b10;
        ex_load_unsigned = 1'b0; ex_register_write = 1'b1; ex_write_address = 5'd3;
        ex_alu_result = 32'h0000_0040; ex_store_data = 32'h0;
        bus_if.bus_ready = 1'b0; bus_if.bus_read_data = 32'h0;
        repeat (3) begin
            @(negedge system_clock); #1;
            total++;
            if (stall !== 1'b0 || bus_if.bus_request !== 1'b0 || wb_valid !== 1'b0 ||
                wb_register_write !== 1'b0 || wb_write_data !== 32'h0 || wb_write_address !== 5'd0 ||
                address_error !== 1'b0 || bus_error !== 1'b0 || bus_if.bus_address !== 32'h0) begin
                bad++; $display("FAIL reset_hold got stall=%b req=%b v=%b d=%h ae=%b be=%b exp all 0",
                                stall, bus_if.bus_request, wb_valid, wb_write_data, address_error, bus_error);
            end
        end
        @(negedge system_clock);
        reset = 1'b0;
        #1;
        total++;
        if (bus_if.bus_request !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b1) begin
            bad++; $display("FAIL reset_release got req=%b v=%b stall=%b exp req=0 v=0 stall=1",
                            bus_if.bus_request, wb_valid, stall);
        end
        run_op(1, 1, 0, 2'b10, 0, 1, 5'd3, 32'h0000_0040, 32'h0, 1, 32'hCAFE_F00D);
    endtask

    task automatic test_alu();
        run_op(1, 0, 0, 2'b10, 0, 1, 5'd5, 32'h1234_5678, $urandom, 0, 32'h0);
        total++;
        if (wb_write_data !== 32'h1234_5678 || wb_write_address !== 5'd5 || obs_stall_cycles != 0) begin
            bad++; $display("FAIL alu_const got d=%h wa=%0d stalls=%0d exp d=12345678 wa=5 stalls=0",
                            wb_write_data, wb_write_address, obs_stall_cycles);
        end
        run_op(1, 0, 0, 2'b00, 0, 1, 5'd0, 32'hDEAD_BEEF, $urandom, 0, 32'h0);
        total++;
        if (wb_write_address !== 5'd0 || wb_register_write !== 1'b1) begin
            bad++; $display("FAIL alu_r0 got wa=%0d rw=%b exp wa=0 rw=1", wb_write_address, wb_register_write);
        end
        run_op(0, 0, 0, 2'b00, 0, 1, 5'd9, 32'h1, 32'h0, 0, 32'h0);
    endtask

    task automatic test_load_byte();
        run_op(1, 1, 0, 2'b00, 0, 1, 5'd7, 32'h0000_1003, $urandom, 3, 32'h80FF_FFFF);
        total++;
        if (wb_write_data !== 32'hFFFF_FF80 || obs_bus_address !== 32'h0000_1000 ||
            obs_be !== 4'b1000 || obs_stall_cycles != 4) begin
            bad++; $display("FAIL lb_const got d=%h a=%h be=%b stalls=%0d exp d=ffffff80 a=00001000 be=1000 stalls=4",
                            wb_write_data, obs_bus_address, obs_be, obs_stall_cycles);
        end
        run_op(1, 1, 0, 2'b00, 1, 1, 5'd7, 32'h0000_1003, $urandom, 3, 32'h80FF_FFFF);
        total++;
        if (wb_write_data !== 32'h0000_0080) begin
            bad++; $display("FAIL lbu_const got=%h exp=00000080", wb_write_data);
        end
    endtask

    task automatic test_store_half();
        run_op(1, 0, 1, 2'b01, 0, 1, 5'd9, 32'h0000_2002, 32'h0000_ABCD, 0, 32'h0);
        total++;
        if (obs_be !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD || wb_register_write !== 1'b0 ||
            wb_valid !== 1'b1 || obs_stall_cycles != 1) begin
            bad++; $display("FAIL sh_const got be=%b wd=%h rw=%b v=%b stalls=%0d exp be=1100 wd=abcdabcd rw=0 v=1 stalls=1",
                            obs_be, obs_wdata, wb_register_write, wb_valid, obs_stall_cycles);
        end
    endtask

    task automatic test_illegal();
        run_op(1, 1, 0, 2'b10, 0, 1, 5'd4, 32'h0000_3002, 32'h0, 0, 32'h0);
        run_op(1, 1, 0, 2'b11, 0, 1, 5'd4, 32'h0000_3000, 32'h0, 0, 32'h0);
        run_op(1, 1, 1, 2'b10, 0, 1, 5'd4, 32'h0000_3000, 32'h0, 0, 32'h0);
        total++;
        if (address_error !== 1'b1 || wb_register_write !== 1'b0 || wb_valid !== 1'b1) begin
            bad++; $display("FAIL illegal_const got ae=%b rw=%b v=%b exp ae=1 rw=0 v=1",
                            address_error, wb_register_write, wb_valid);
        end
        ex_valid = 1'b0;
        @(posedge system_clock); @(negedge system_clock); #1;
        total++;
        if (address_error !== 1'b0 || wb_valid !== 1'b0) begin
            bad++; $display("FAIL addr_err_pulse got ae=%b v=%b exp ae=0 v=0", address_error, wb_valid);
        end
    endtask

    task automatic test_timeout();
        run_op(1, 1, 0, 2'b10, 0, 1, 5'd12, 32'h0000_4000, 32'h0, 1000, 32'h0);
        total++;
        if (obs_req_cycles != T || bus_error !== 1'b1 || wb_register_write !== 1'b0) begin
            bad++; $display("FAIL timeout_const got req_cycles=%0d be=%b rw=%b exp req_cycles=%0d be=1 rw=0",
                            obs_req_cycles, bus_error, wb_register_write, T);
        end
        ex_valid = 1'b0;
        @(posedge system_clock); @(negedge system_clock); #1;
        total++;
        if (bus_error !== 1'b0 || wb_valid !== 1'b0 || bus_if.bus_request !== 1'b0) begin
            bad++; $display("FAIL bus_err_pulse got be=%b v=%b req=%b exp 0 0 0",
                            bus_error, wb_valid, bus_if.bus_request);
        end
    endtask

    task automatic test_reset_mid_access();
        ex_valid = 1'b1; ex_memory_read = 1'b1; ex_memory_write = 1'b0; ex_access_size = 2'b10;
        ex_load_unsigned = 1'b0; ex_register_write = 1'b1; ex_write_address = 5'd6;
        ex_alu_result = 32'h0000_5000; bus_if.bus_ready = 1'b0;
        repeat (2) begin
            @(posedge system_clock); @(negedge system_clock);
        end
        #1;
        total++;
        if (bus_if.bus_request !== 1'b1) begin
            bad++; $display("FAIL mid_req got=%b exp=1", bus_if.bus_request);
        end
        reset = 1'b1; bus_if.bus_ready = 1'b1; bus_if.bus_read_data = 32'h1111_2222;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL mid_stall got=%b exp=0", stall);
        end
        @(posedge system_clock); @(negedge system_clock); #1;
        total++;
        if (bus_if.bus_request !== 1'b0 || bus_error !== 1'b0 || wb_valid !== 1'b0) begin
            bad++; $display("FAIL mid_reset got req=%b be=%b v=%b exp 0 0 0",
                            bus_if.bus_request, bus_error, wb_valid);
        end
        reset = 1'b0; ex_valid = 1'b0;
        @(posedge system_clock); @(negedge system_clock); #1;
        total++;
        if (wb_valid !== 1'b0 || bus_error !== 1'b0 || bus_if.bus_request !== 1'b0) begin
            bad++; $display("FAIL late_ready got v=%b be=%b req=%b exp 0 0 0",
                            wb_valid, bus_error, bus_if.bus_request);
        end
        bus_if.bus_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_op(1, 1, 0, 2'b10, 0, 1, 5'd1, 32'h0000_6004, 32'h0, 0, 32'h0BAD_F00D);
        run_op(1, 0, 1, 2'b00, 0, 0, 5'd2, 32'h0000_6001, 32'h0000_005A, 0, 32'h0);
        run_op(1, 1, 0, 2'b01, 0, 1, 5'd3, 32'h0000_6006, 32'h0, 2, 32'h8001_7FFF);
        run_op(1, 0, 0, 2'b00, 0, 1, 5'd4, 32'h0000_0077, 32'h0, 0, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            int          kind;
            logic        rd, wr, v;
            logic [1:0]  sz;
            logic [31:0] alu;
            kind = $urandom_range(0, 9);
            v  = (kind != 0);
            rd = (kind >= 3 && kind <= 5) || kind == 9;
            wr = (kind >= 6);
            sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            alu = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) alu[0] = 1'b0;
                if (sz == 2'b10) alu[1:0] = 2'b00;
            end
            run_op(v, rd, wr, sz, 1'($urandom), 1'($urandom), 5'($urandom), alu, $urandom,
                   $urandom_range(0, 5), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_byte();
        test_store_half();
        test_illegal();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        ex_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
